// File: rtl/score_keeper.sv
`timescale 1ns/1ps
// score_keeper
//
// Game-side scorekeeper that works with the menu. It starts a game on the menu's
// start handshake and counts a point for each ball-to-floor contact. Between
// points it holds a serve pause. When a player wins it reports endgame back to
// the menu and waits for the menu to close the game.
//
// Every output is registered, so each output changes one clock after the input
// that causes it.
//
// Ports:
//   clk          in   pixel clock; all logic runs on the rising edge
//   rst          in   asynchronous, active-low reset
//   mousecontrol in   from the menu; 1 = game started or running
//   enable_menu  in   from the menu; 1 = menu screen shown
//   ground_left  in   1-cycle pulse: ball hit the floor on the left half (point to right)
//   ground_right in   1-cycle pulse: ball hit the floor on the right half (point to left)
//   score_left   out  left player score
//   score_right  out  right player score
//   flag_point   out  high for the whole serve pause after a point
//   endgame      out  high while a finished game waits for the menu
//   winner       out  0 = left won, 1 = right won; valid while endgame = 1
//   freeze       out  physics hold (idle, serve pause, game over)
//   ball_reset   out  1-cycle pulse: re-place the ball for a serve
//   serve_right  out  side that serves next (scorer of the last point, right = 1)

module score_keeper #(
    parameter int unsigned WIN_SCORE   = 15,
    parameter int unsigned SERVE_DELAY = 65_000_000,
    parameter int unsigned SCORE_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mousecontrol,
    input  logic               enable_menu,
    input  logic               ground_left,
    input  logic               ground_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               flag_point,
    output logic               endgame,
    output logic               winner,
    output logic               freeze,
    output logic               ball_reset,
    output logic               serve_right
);

    localparam int unsigned CntW = $clog2(SERVE_DELAY);

    localparam logic [SCORE_W-1:0] WinVal  = SCORE_W'(WIN_SCORE);
    localparam logic [CntW-1:0]    CntLast = CntW'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPoint = 2'd2,
        StEnd   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               flag_point_q, flag_point_d;
    logic               endgame_q, endgame_d;
    logic               winner_q, winner_d;
    logic               freeze_q, freeze_d;
    logic               ball_reset_q, ball_reset_d;
    logic               serve_right_q, serve_right_d;

    // Each score plus one, computed once so the win test and the update use the same value.
    logic [SCORE_W-1:0] left_inc;
    logic [SCORE_W-1:0] right_inc;

    assign left_inc  = score_left_q + 1'b1;
    assign right_inc = score_right_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        serve_right_d = serve_right_q;
        ball_reset_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mousecontrol && !enable_menu) begin
                    state_d       = StPlay;
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_right_d = 1'b0;
                    ball_reset_d  = 1'b1;
                end
            end

            StPlay: begin
                if (!mousecontrol) begin
                    // The menu has aborted the game. Keep the scores on screen.
                    state_d = StIdle;
                end else if (ground_right && !ground_left) begin
                    score_left_d  = left_inc;
                    serve_right_d = 1'b0;
                    cnt_d         = '0;
                    if (left_inc == WinVal) begin
                        state_d  = StEnd;
                        winner_d = 1'b0;
                    end else begin
                        state_d = StPoint;
                    end
                end else if (ground_left && !ground_right) begin
                    score_right_d = right_inc;
                    serve_right_d = 1'b1;
                    cnt_d         = '0;
                    if (right_inc == WinVal) begin
                        state_d  = StEnd;
                        winner_d = 1'b1;
                    end else begin
                        state_d = StPoint;
                    end
                end
                // Both pulses in the same cycle cancel each other, so nothing changes.
            end

            StPoint: begin
                // Ground pulses are ignored during the pause.
                if (!mousecontrol) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d      = StPlay;
                    cnt_d        = '0;
                    ball_reset_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StEnd: begin
                if (!mousecontrol) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Compute these flags from the next state. The registered copies then match the
        // state that the same clock edge enters.
        flag_point_d = (state_d == StPoint);
        endgame_d    = (state_d == StEnd);
        freeze_d     = (state_d != StPlay);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            score_left_q  <= '0;
            score_right_q <= '0;
            flag_point_q  <= 1'b0;
            endgame_q     <= 1'b0;
            winner_q      <= 1'b0;
            freeze_q      <= 1'b1;
            ball_reset_q  <= 1'b0;
            serve_right_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            flag_point_q  <= flag_point_d;
            endgame_q     <= endgame_d;
            winner_q      <= winner_d;
            freeze_q      <= freeze_d;
            ball_reset_q  <= ball_reset_d;
            serve_right_q <= serve_right_d;
        end
    end

    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign flag_point  = flag_point_q;
    assign endgame     = endgame_q;
    assign winner      = winner_q;
    assign freeze      = freeze_q;
    assign ball_reset  = ball_reset_q;
    assign serve_right = serve_right_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side counterpart of the menu: consumes the menu's game-start handshake (mousecontrol, enable_menu) and ball ground-contact events, keeps both players' scores, and returns endgame and flag_point to the menu.
- Runs a PLAY / POINT (serve pause) / END sequence, and freezes physics during pauses.
- Sits between the ball/physics logic and the menu on the 65 MHz pixel clock domain.

Parameters:
- WIN_SCORE, 15, score at which a player wins; 1..31.
- SERVE_DELAY, 65_000_000, cycles of the post-point pause (1 s at 65 MHz); must be >= 2.
- SCORE_W, 5, width of the score outputs.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mousecontrol  in  1  from menu; 1 = game started/running.
- enable_menu  in  1  from menu; 1 = menu screen shown.
- ground_left  in  1  single-cycle pulse: ball touched floor on left half; point to right player.
- ground_right  in  1  single-cycle pulse: ball touched floor on right half; point to left player.
- score_left  out  SCORE_W  left player score.
- score_right  out  SCORE_W  right player score.
- flag_point  out  1  high for the whole POINT pause.
- endgame  out  1  high in END state.
- winner  out  1  0 = left won, 1 = right won; valid while endgame = 1.
- freeze  out  1  high when physics must hold (IDLE, POINT, END).
- ball_reset  out  1  one-cycle pulse: re-place ball for serve.
- serve_right  out  1  side serving next; equals the last point's scorer (right = 1).

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; scores = 0; flag_point = 0; endgame = 0; winner = 0; freeze = 1; ball_reset = 0; serve_right = 0; delay counter = 0.
- All outputs are registered; each output changes on the clock edge after the causing input is sampled (1-cycle latency).
- IDLE:
  - freeze = 1.
  - When mousecontrol = 1 and enable_menu = 0: go to PLAY; clear both scores; serve_right = 0; pulse ball_reset for 1 cycle.
- PLAY:
  - freeze = 0.
  - ground_right only: score_left += 1; serve_right = 0.
  - ground_left only: score_right += 1; serve_right = 1.
  - Both in the same cycle: no score change; stay in PLAY.
  - After a scoring event:
    - If the incremented score equals WIN_SCORE: go to END; winner = scorer.
    - Otherwise: go to POINT with counter = 0.
- POINT:
  - flag_point = 1; freeze = 1.
  - Counter increments every cycle.
  - At counter = SERVE_DELAY-1: go to PLAY, pulse ball_reset, flag_point = 0.
  - Ground pulses are ignored.
- END:
  - endgame = 1; freeze = 1; scores held; ground pulses ignored.
  - endgame stays high until mousecontrol = 0, then go to IDLE on the next edge (endgame = 0).
  - Scores stay visible in IDLE until the next start.
- Abort: in PLAY or POINT, if mousecontrol = 0, go to IDLE; scores held; flag_point = 0.
- Scores never exceed WIN_SCORE; no wrap-around. SCORE_W must hold WIN_SCORE.
- Counter width is clog2(SERVE_DELAY). The counter is cleared on every entry to POINT.
- Reset asserted mid-POINT or mid-END returns everything to reset values immediately, without waiting for a clock edge.

Test Plan (WIN_SCORE = 3, SERVE_DELAY = 4 unless stated):
- Reset: hold rst = 0 for 3 cycles, then release.
  - Required: scores 0/0, freeze = 1, endgame = 0, flag_point = 0, state IDLE.
- Start: mousecontrol = 1, enable_menu = 0.
  - Required: next edge ball_reset = 1 for exactly 1 cycle, freeze = 0.
- Point and pause: ground_right pulse in PLAY.
  - Required: score_left = 1, flag_point = 1 for exactly 4 cycles, then ball_reset pulse; serve_right = 0.
  - A ground_left pulse during the pause leaves score_right = 0.
- Simultaneous: ground_left and ground_right in the same cycle.
  - Required: both scores unchanged; flag_point stays 0.
- Win and menu handshake: three ground_left pulses, each after its pause.
  - Required: score_right = 3, endgame = 1, winner = 1; endgame held while mousecontrol = 1.
  - Drop mousecontrol: IDLE on the next edge, endgame = 0, scores stay 0/3.
  - Restart: scores 0/0.
- Async reset mid-POINT: rst low between clock edges.
  - Required: outputs reach reset values before the next clk edge; flag_point = 0.
